// File: rtl/data_mem_controller_pkg.sv
// Shared core package: core/LSU state encodings and the data-memory controller FSM encoding.
package data_mem_controller_pkg;

  typedef enum logic [2:0] {
    CoreIdle, CoreFetch, CoreDecode, CoreRequest, CoreWait, CoreExecute, CoreUpdate, CoreDone
  } core_state_e;

  typedef enum logic [1:0] {
    LsuIdle, LsuRequesting, LsuWaiting, LsuDone
  } lsu_state_e;

  typedef enum logic [1:0] {
    MemIdle, MemReadWaiting, MemWriteWaiting, MemRelaying
  } mem_ctrl_state_e;

  // Pointer width that stays legal for a single consumer.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/data_mem_controller_rr_arbiter.sv
// Combinational round-robin selector: first requester at or after ptr, one-hot grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PTR_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic                grant_valid
);

  // Offset k is tried before k+1; inner loop maps the offset to a constant index.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!grant_valid && req[j] && (((32'(ptr) + k) % NUM_REQ) == j)) begin
          grant[j]    = 1'b1;
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_controller.sv
// Arbitrates per-core LSU read/write requests onto a single data-memory port.
module data_mem_controller
  import data_mem_controller_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int unsigned PtrBits = ptr_width(NUM_CONSUMERS);

  mem_ctrl_state_e          state_q;
  logic [PtrBits-1:0]       rr_ptr_q, ptr_next;
  logic [NUM_CONSUMERS-1:0] req_any, grant, grant_q;
  logic                     grant_valid, op_write_q, sel_is_read, rel_valid;
  logic [ADDR_BITS-1:0]     sel_raddr, sel_waddr;
  logic [DATA_BITS-1:0]     sel_wdata;

  assign req_any = consumer_read_valid | consumer_write_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_CONSUMERS),
    .PTR_BITS(PtrBits)
  ) u_rr_arbiter (
    .req        (req_any),
    .ptr        (rr_ptr_q),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  // Read wins when the granted consumer asserts both.
  assign sel_is_read = |(grant & consumer_read_valid);
  assign rel_valid   = op_write_q ? |(grant_q & consumer_write_valid)
                                  : |(grant_q & consumer_read_valid);

  always_comb begin
    sel_raddr = '0;
    sel_waddr = '0;
    sel_wdata = '0;
    ptr_next  = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      if (grant[i]) begin
        sel_raddr = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        sel_waddr = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        sel_wdata = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        ptr_next  = PtrBits'((i + 1) % NUM_CONSUMERS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= MemIdle;
      rr_ptr_q             <= '0;
      grant_q              <= '0;
      op_write_q           <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      unique case (state_q)
        MemIdle: begin
          if (grant_valid) begin
            grant_q  <= grant;
            rr_ptr_q <= ptr_next;
            if (sel_is_read) begin
              op_write_q       <= 1'b0;
              mem_read_valid   <= 1'b1;
              mem_read_address <= sel_raddr;
              state_q          <= MemReadWaiting;
            end else begin
              op_write_q        <= 1'b1;
              mem_write_valid   <= 1'b1;
              mem_write_address <= sel_waddr;
              mem_write_data    <= sel_wdata;
              state_q           <= MemWriteWaiting;
            end
          end
        end
        MemReadWaiting: begin
          if (mem_read_ready) begin
            mem_read_valid      <= 1'b0;
            consumer_read_ready <= grant_q;
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
              if (grant_q[i]) consumer_read_data[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
            end
            state_q <= MemRelaying;
          end
        end
        MemWriteWaiting: begin
          if (mem_write_ready) begin
            mem_write_valid      <= 1'b0;
            consumer_write_ready <= grant_q;
            state_q              <= MemRelaying;
          end
        end
        MemRelaying: begin
          if (!rel_valid) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            state_q              <= MemIdle;
          end
        end
        default: state_q <= MemIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Scoreboard bench: round-robin reference model, behavioural memory responder, ready monitor.
module tb_data_mem_controller;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    consumer_read_valid, consumer_read_ready;
  logic [N-1:0]    consumer_write_valid, consumer_write_ready;
  logic [N*AW-1:0] consumer_read_address, consumer_write_address;
  logic [N*DW-1:0] consumer_read_data, consumer_write_data;
  logic            mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [AW-1:0]   mem_read_address, mem_write_address;
  logic [DW-1:0]   mem_read_data, mem_write_data;

  data_mem_controller #(
    .NUM_CONSUMERS(N),
    .ADDR_BITS    (AW),
    .DATA_BITS    (DW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .consumer_write_valid  (consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data   (consumer_write_data),
    .consumer_write_ready  (consumer_write_ready),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mem_read_ready),
    .mem_read_data         (mem_read_data),
    .mem_write_valid       (mem_write_valid),
    .mem_write_address     (mem_write_address),
    .mem_write_data        (mem_write_data),
    .mem_write_ready       (mem_write_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   cons;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          exp_q[$];
  txn_t          obs_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem_store[256];
  logic [DW-1:0] model_mem[256];
  logic [DW-1:0] exp_rdata[N];
  int unsigned   model_ptr = 0;
  int            lat_fixed = -1;
  bit            hold_mem = 1'b0;
  logic [AW-1:0] ra[N], wa[N];
  logic [DW-1:0] wd[N];

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] rdata_vec();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = exp_rdata[i];
    return v;
  endfunction

  task automatic check_reset_outputs();
    check(mem_read_valid == 1'b0, "rst_mem_read_valid", mem_read_valid, 0);
    check(mem_write_valid == 1'b0, "rst_mem_write_valid", mem_write_valid, 0);
    check(mem_read_address == '0, "rst_mem_read_address", mem_read_address, 0);
    check(mem_write_address == '0, "rst_mem_write_address", mem_write_address, 0);
    check(mem_write_data == '0, "rst_mem_write_data", mem_write_data, 0);
    check(consumer_read_ready == '0, "rst_read_ready", consumer_read_ready, 0);
    check(consumer_write_ready == '0, "rst_write_ready", consumer_write_ready, 0);
    check(consumer_read_data == '0, "rst_read_data", consumer_read_data, 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    obs_q.delete();
    model_ptr = 0;
    for (int i = 0; i < N; i++) exp_rdata[i] = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    clear_model();
    reset = 1'b1;
  endtask

  // Memory responder: latches each request, checks it holds steady, answers after a latency.
  initial begin
    logic          active;
    int            wait_cnt;
    bit            cur_wr;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    active = 1'b0; wait_cnt = 0; cur_wr = 1'b0; cur_addr = '0; cur_data = '0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    forever begin
      @(negedge clk);
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      mem_read_data   = DW'($urandom);
      if (reset !== 1'b1) begin
        active = 1'b0;
      end else if (mem_read_valid || mem_write_valid) begin
        if (!active) begin
          active   = 1'b1;
          cur_wr   = mem_write_valid;
          cur_addr = cur_wr ? mem_write_address : mem_read_address;
          cur_data = mem_write_data;
          wait_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
        end else begin
          if (cur_wr)
            check(mem_write_valid && mem_write_address == cur_addr && mem_write_data == cur_data,
                  "mem_write_stable", {mem_write_valid, mem_write_address, mem_write_data},
                  {1'b1, cur_addr, cur_data});
          else
            check(mem_read_valid && !mem_write_valid && mem_read_address == cur_addr,
                  "mem_read_stable", {mem_read_valid, mem_read_address}, {1'b1, cur_addr});
          check((consumer_read_ready | consumer_write_ready) == '0, "no_ready_while_waiting",
                {consumer_read_ready, consumer_write_ready}, 0);
        end
        if (!hold_mem) begin
          if (wait_cnt == 0) begin
            if (cur_wr) begin
              mem_write_ready    = 1'b1;
              mem_store[cur_addr] = cur_data;
            end else begin
              mem_read_ready = 1'b1;
              mem_read_data  = mem_store[cur_addr];
            end
            obs_q.push_back('{cons: 0, wr: cur_wr, addr: cur_addr,
                              data: cur_wr ? cur_data : mem_store[cur_addr]});
            active = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
      end else if (active) begin
        check(1'b0, "mem_valid_dropped_early", 0, 1);
        active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check($countones(consumer_read_ready | consumer_write_ready) <= 1, "one_ready_max",
            {consumer_read_ready, consumer_write_ready}, 0);
      check(!(mem_read_valid && mem_write_valid), "one_mem_valid_max",
            {mem_read_valid, mem_write_valid}, 0);
    end
  end

  task automatic complete(input int i, input bit wr);
    txn_t e, o;
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_ready", i * 2 + int'(wr), 0);
    end else begin
      e = exp_q.pop_front();
      check(e.cons == i && e.wr == wr, "grant_order", i * 2 + int'(wr), e.cons * 2 + e.wr);
      if (obs_q.size() == 0) begin
        check(1'b0, "mem_txn_missing", 0, 1);
      end else begin
        o = obs_q.pop_front();
        check(o.wr == e.wr && o.addr == e.addr, "mem_address", {o.wr, o.addr}, {e.wr, e.addr});
        if (e.wr) check(o.data == e.data, "mem_write_data", o.data, e.data);
      end
      if (!e.wr) exp_rdata[e.cons] = e.data;
      check(consumer_read_data == rdata_vec(), "read_data", consumer_read_data, rdata_vec());
    end
    if (wr) consumer_write_valid[i] = 1'b0;
    else consumer_read_valid[i] = 1'b0;
  endtask

  logic [N-1:0] prev_rr = '0, prev_wr = '0;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_rr = '0;
      prev_wr = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (consumer_read_ready[i] && !prev_rr[i]) complete(i, 1'b0);
        if (consumer_write_ready[i] && !prev_wr[i]) complete(i, 1'b1);
      end
      prev_rr = consumer_read_ready;
      prev_wr = consumer_write_ready;
    end
  end

  // Model: pending requests served one at a time, scanning from the pointer, read before write.
  task automatic run_batch(input logic [N-1:0] rd, input logic [N-1:0] wr);
    logic [N-1:0] pr, pw;
    int           cyc;
    pr = rd;
    pw = wr;
    while ((pr | pw) != '0) begin
      for (int unsigned k = 0; k < N; k++) begin
        int unsigned c;
        c = (model_ptr + k) % N;
        if (pr[c] || pw[c]) begin
          if (pr[c]) begin
            exp_q.push_back('{cons: c, wr: 1'b0, addr: ra[c], data: model_mem[ra[c]]});
            pr[c] = 1'b0;
          end else begin
            exp_q.push_back('{cons: c, wr: 1'b1, addr: wa[c], data: wd[c]});
            model_mem[wa[c]] = wd[c];
            pw[c] = 1'b0;
          end
          model_ptr = (c + 1) % N;
          break;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      consumer_read_address[i*AW +: AW]  = ra[i];
      consumer_write_address[i*AW +: AW] = wa[i];
      consumer_write_data[i*DW +: DW]    = wd[i];
    end
    consumer_read_valid  = rd;
    consumer_write_valid = wr;
    cyc = 0;
    while (((consumer_read_valid | consumer_write_valid) != '0 || exp_q.size() != 0) && cyc < 500)
    begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 500) begin
      check(1'b0, "batch_timeout", exp_q.size(), 0);
      apply_reset();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_during_write();
    int cyc;
    hold_mem = 1'b1;
    wa[1] = AW'($urandom);
    wd[1] = DW'($urandom);
    @(negedge clk);
    consumer_write_address[1*AW +: AW] = wa[1];
    consumer_write_data[1*DW +: DW]    = wd[1];
    consumer_write_valid[1]            = 1'b1;
    cyc = 0;
    while (!mem_write_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check(mem_write_valid == 1'b1, "write_waiting_reached", mem_write_valid, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_outputs();
    consumer_write_valid = '0;
    clear_model();
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    hold_mem = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check(consumer_write_ready == '0, "no_write_ready_after_reset", consumer_write_ready, 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    consumer_read_valid = '0; consumer_write_valid = '0;
    consumer_read_address = '0; consumer_write_address = '0; consumer_write_data = '0;
    for (int a = 0; a < 256; a++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      mem_store[a] = v;
      model_mem[a] = v;
    end
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; wa[i] = '0; wd[i] = '0; exp_rdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;

    // Core 2 reads 0x10, memory answers 0xA5 after a fixed delay.
    mem_store[8'h10] = 8'hA5;
    model_mem[8'h10] = 8'hA5;
    lat_fixed = 3;
    ra[2] = 8'h10;
    run_batch(4'b0100, 4'b0000);
    check(consumer_read_data[2*DW +: DW] == 8'hA5, "core2_reads_a5",
          consumer_read_data[2*DW +: DW], 8'hA5);
    lat_fixed = -1;
    apply_reset();

    // All cores read at once, then pointer should be back at 0.
    for (int i = 0; i < N; i++) ra[i] = AW'($urandom);
    run_batch(4'b1111, 4'b0000);
    run_batch(4'b1001, 4'b0000);

    // Core 3 writes 0x7E to 0x20; pointer wraps so core 0 goes next.
    wa[3] = 8'h20;
    wd[3] = 8'h7E;
    run_batch(4'b0000, 4'b1000);
    ra[0] = 8'h20;
    ra[2] = AW'($urandom);
    run_batch(4'b0101, 4'b0000);
    check(consumer_read_data[DW-1:0] == 8'h7E, "core0_reads_7e", consumer_read_data[DW-1:0], 8'h7E);

    // Core 1 asserts read and write together.
    ra[1] = AW'($urandom); wa[1] = AW'($urandom); wd[1] = DW'($urandom); ra[2] = AW'($urandom);
    run_batch(4'b0110, 4'b0010);

    // Long memory stall on a read.
    lat_fixed = 20;
    ra[0] = AW'($urandom);
    run_batch(4'b0001, 4'b0000);
    lat_fixed = -1;

    reset_during_write();

    for (int b = 0; b < 40; b++) begin
      logic [N-1:0] rd, wr;
      rd = N'($urandom);
      wr = N'($urandom);
      if ((rd | wr) == '0) rd = 4'b0001;
      for (int i = 0; i < N; i++) begin
        ra[i] = AW'($urandom_range(0, 15));
        wa[i] = AW'($urandom_range(0, 15));
        wd[i] = DW'($urandom);
      end
      run_batch(rd, wr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
